// File: rtl/vga_pkg.sv
// Shared VGA timing constants, board token encoding and grid type.
// Used by the video driver, the screen drawer and the frame decoder.
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ROWS     = 6;
  localparam int COLS     = 7;
  localparam int TILE_X0  = 40;
  localparam int TILE_Y0  = 0;
  localparam int TILE_W   = 80;
  localparam int LOCK_FRM = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2
  } token_t;

  typedef logic [0:ROWS-1][0:COLS-1][1:0] tile_grid_t;

  typedef enum logic [1:0] {
    HUNT,
    ACQ,
    LOCKED
  } sync_state_t;

  // Only the channel MSBs matter: red -> P1, yellow -> P2.
  function automatic token_t classify(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    logic rh, gh, bh;
    rh = (r >= 8'h80);
    gh = (g >= 8'h80);
    bh = (b >= 8'h80);
    classify = EMPTY;
    if (rh && !bh)
      classify = gh ? P2 : P1;
  endfunction

endpackage

// File: rtl/vga_sync_checker.sv
// Sync edge detection, line/frame length checks and the lock FSM.
// Publishes a frame_ok strobe on every clean frame end while locked.
module vga_sync_checker
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int LOCK_FRM = vga_pkg::LOCK_FRM
) (
  input  logic clk,
  input  logic reset,
  input  logic vga_hs,
  input  logic vga_vs,
  output logic vs_fall,
  output logic h_err,
  output logic v_err,
  output logic locked,
  output logic frame_ok
);

  sync_state_t state, state_n;

  logic        prev_hs, prev_vs;
  logic        hs_fall;
  logic [9:0]  h_cnt, v_cnt;
  logic        h_armed;
  logic        dirty;
  logic [3:0]  clean_cnt;
  logic        h_bad, v_bad, clean;

  assign hs_fall = prev_hs & ~vga_hs;
  assign vs_fall = prev_vs & ~vga_vs;

  // A coincident hs_fall closes the last line of the frame.
  always_comb begin
    h_bad = hs_fall & h_armed & (state != HUNT) &
            (({1'b0, h_cnt} + 11'd1) != 11'(H_TOTAL));
    v_bad = vs_fall & (state != HUNT) &
            (({1'b0, v_cnt} + {10'd0, hs_fall}) != 11'(V_TOTAL));
    clean = ~dirty & ~h_bad & ~v_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_hs <= 1'b1;
      prev_vs <= 1'b1;
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_armed <= 1'b0;
      dirty   <= 1'b0;
      h_err   <= 1'b0;
      v_err   <= 1'b0;
    end else begin
      prev_hs <= vga_hs;
      prev_vs <= vga_vs;
      h_cnt   <= hs_fall ? '0
               : h_cnt + {9'd0, h_cnt != 10'h3ff};
      if (vs_fall)
        v_cnt <= '0;
      else if (hs_fall && v_cnt != 10'h3ff)
        v_cnt <= v_cnt + 10'd1;
      if (hs_fall && state != HUNT)
        h_armed <= 1'b1;
      if (vs_fall)
        dirty <= 1'b0;
      else if (h_bad)
        dirty <= 1'b1;
      h_err <= h_bad;
      v_err <= v_bad;
    end
  end

  // The acquiring vs edge counts as the first boundary of a clean run.
  always_ff @(posedge clk) begin
    if (reset) begin
      clean_cnt <= '0;
    end else begin
      unique case (state)
        HUNT:
          if (vs_fall) clean_cnt <= 4'd1;
        ACQ:
          if (vs_fall) clean_cnt <= clean ? clean_cnt + 4'd1 : '0;
        default:
          clean_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= HUNT;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      HUNT:
        if (vs_fall) state_n = ACQ;
      ACQ:
        if (vs_fall && clean &&
            ({1'b0, clean_cnt} + 5'd1) >= 5'(LOCK_FRM))
          state_n = LOCKED;
      LOCKED:
        if (h_bad || v_bad) state_n = ACQ;
      default:
        state_n = HUNT;
    endcase
  end

  always_comb begin
    locked   = (state == LOCKED);
    frame_ok = vs_fall & (state == LOCKED) & clean;
  end

endmodule

// File: rtl/vga_frame_decoder.sv
// VGA receive side: recovers x/y, samples tile centres and rebuilds
// the token grid, publishing it on clean frame ends once locked.
module vga_frame_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int TILE_X0  = vga_pkg::TILE_X0,
  parameter int TILE_Y0  = vga_pkg::TILE_Y0,
  parameter int TILE_W   = vga_pkg::TILE_W,
  parameter int LOCK_FRM = vga_pkg::LOCK_FRM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic       vga_blank_n,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       locked,
  output tile_grid_t tiles,
  output logic       tiles_valid,
  output logic       h_err,
  output logic       v_err
);

  logic       vs_fall;
  logic       frame_ok;
  logic [9:0] x_cnt, y_cnt;
  logic       prev_blank;
  tile_grid_t shadow;

  vga_sync_checker #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .LOCK_FRM (LOCK_FRM)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .vga_hs   (vga_hs),
    .vga_vs   (vga_vs),
    .vs_fall  (vs_fall),
    .h_err    (h_err),
    .v_err    (v_err),
    .locked   (locked),
    .frame_ok (frame_ok)
  );

  assign x = vga_blank_n ? x_cnt : '0;
  assign y = y_cnt;

  // y counts completed active lines since the last vertical sync.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      prev_blank <= 1'b0;
    end else begin
      prev_blank <= vga_blank_n;
      x_cnt      <= vga_blank_n ? x_cnt + 10'd1 : '0;
      if (vs_fall)
        y_cnt <= '0;
      else if (prev_blank && !vga_blank_n)
        y_cnt <= y_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (vga_blank_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (x_cnt == 10'(TILE_X0 + c*TILE_W + TILE_W/2) &&
              y_cnt == 10'(TILE_Y0 + r*TILE_W + TILE_W/2))
            shadow[r][c] <= classify(vga_r, vga_g, vga_b);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tiles       <= '0;
      tiles_valid <= 1'b0;
    end else begin
      tiles_valid <= frame_ok;
      if (frame_ok)
        tiles <= shadow;
    end
  end

endmodule

// File: tb/tb_vga_frame_decoder.sv
// Directed bench for vga_frame_decoder on a scaled-down raster
// (40x30 totals, 4-pixel tiles) so whole frames stay short.
module tb_vga_frame_decoder;
  import vga_pkg::*;

  localparam int HT  = 40;
  localparam int VT  = 30;
  localparam int X0  = 2;
  localparam int Y0  = 0;
  localparam int TW  = 4;
  localparam int HA  = 32;
  localparam int VA  = 24;
  localparam int HS0 = 34;
  localparam int HS1 = 38;
  localparam int VSL = 26;

  logic       clk = 1'b0;
  logic       reset;
  logic       vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;
  logic [9:0] x, y;
  logic       locked, tiles_valid, h_err, v_err;
  tile_grid_t tiles;

  int n_total = 0;
  int n_pass  = 0;
  int tv_cnt  = 0;
  int tv_long = 0;
  int herr_cnt = 0;
  int verr_cnt = 0;
  logic tv_prev = 1'b0;

  int row5_a [7] = '{1, 1, 1, 2, 0, 1, 1};

  always #5 clk = ~clk;

  vga_frame_decoder #(
    .H_TOTAL  (HT),
    .V_TOTAL  (VT),
    .TILE_X0  (X0),
    .TILE_Y0  (Y0),
    .TILE_W   (TW),
    .LOCK_FRM (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .x           (x),
    .y           (y),
    .locked      (locked),
    .tiles       (tiles),
    .tiles_valid (tiles_valid),
    .h_err       (h_err),
    .v_err       (v_err)
  );

  always @(negedge clk) begin
    if (tiles_valid) tv_cnt++;
    if (tiles_valid && tv_prev) tv_long++;
    tv_prev = tiles_valid;
    if (h_err) herr_cnt++;
    if (v_err) verr_cnt++;
  end

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Colour codes: 0 blue, 1 red, 2 yellow, 3 dark red (below MSB).
  function automatic int pat(input int k, input int r, input int c);
    case (k)
      0:       pat = (r == 5) ? row5_a[c] : (r*7 + c) % 4;
      1:       pat = (r + c) % 4;
      2:       pat = (r*3 + c*2 + 1) % 4;
      default: pat = (c*5 + r + 2) % 4;
    endcase
  endfunction

  function automatic tile_grid_t grid_of(input int k);
    tile_grid_t g;
    int code;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        code = pat(k, r, c);
        g[r][c] = (code == 1) ? 2'd1 : (code == 2) ? 2'd2 : 2'd0;
      end
    return g;
  endfunction

  task automatic set_rgb(input int code);
    case (code)
      0:       {vga_r, vga_g, vga_b} = {8'h00, 8'h00, 8'hFF};
      1:       {vga_r, vga_g, vga_b} = {8'hFF, 8'h00, 8'h00};
      2:       {vga_r, vga_g, vga_b} = {8'hFF, 8'hFF, 8'h00};
      default: {vga_r, vga_g, vga_b} = {8'h7F, 8'h00, 8'h00};
    endcase
  endtask

  task automatic run_frame(input int k, input int lines,
                           input int short_line, input int rst_line);
    int len;
    logic act;
    for (int l = 0; l < lines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        @(negedge clk);
        reset  = (l == rst_line) && (p < 3);
        vga_hs = !(p >= HS0 && p < HS1);
        vga_vs = !((l == VSL && p >= HS0) || l == VSL + 1 ||
                   (l == VSL + 2 && p < HS0));
        act = (p < HA) && (l < VA);
        vga_blank_n = act;
        if (act && p >= X0 && p < X0 + 7*TW)
          set_rgb(pat(k, l / TW, (p - X0) / TW));
        else
          {vga_r, vga_g, vga_b} = {8'h80, 8'h80, 8'h80};
        #1;
        if (k == 0 && l == 3 && p == 17) begin
          check("x_active", 128'(x), 128'(17));
          check("y_active", 128'(y), 128'(3));
        end
        if (k == 0 && l == 3 && p == 35)
          check("x_blank", 128'(x), 128'(0));
        if (l == rst_line && p == 1) begin
          check("rst_locked", 128'(locked), 128'(0));
          check("rst_tv", 128'(tiles_valid), 128'(0));
          check("rst_herr", 128'(h_err), 128'(0));
          check("rst_verr", 128'(v_err), 128'(0));
        end
        if (l == rst_line && p == 3) begin
          check("rst_tiles", 128'(tiles), 128'(0));
          check("rst_x", 128'(x), 128'(0));
          check("rst_y", 128'(y), 128'(0));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    vga_hs = 1'b1;
    vga_vs = 1'b1;
    vga_blank_n = 1'b0;
    {vga_r, vga_g, vga_b} = '0;
    repeat (3) @(negedge clk);
    #1;
    check("por_x", 128'(x), 128'(0));
    check("por_y", 128'(y), 128'(0));
    check("por_locked", 128'(locked), 128'(0));
    check("por_tiles", 128'(tiles), 128'(0));
    check("por_tv", 128'(tiles_valid), 128'(0));
    check("por_herr", 128'(h_err), 128'(0));
    check("por_verr", 128'(v_err), 128'(0));

    // Clean frames, vs falling together with hs.
    run_frame(0, VT, -1, -1);
    check("f0_locked", 128'(locked), 128'(0));
    check("f0_tv", 128'(tv_cnt), 128'(0));
    run_frame(0, VT, -1, -1);
    check("f1_locked", 128'(locked), 128'(1));
    check("f1_tv", 128'(tv_cnt), 128'(0));
    run_frame(0, VT, -1, -1);
    check("f2_tv", 128'(tv_cnt), 128'(1));
    check("f2_tv_len", 128'(tv_long), 128'(0));
    check("f2_tiles", 128'(tiles), 128'(grid_of(0)));
    check("f2_row5", 128'(tiles[5]),
          128'(14'b01_01_01_10_00_01_01));
    check("f2_blue", 128'(tiles[0][0]), 128'(2'd0));
    check("f2_red", 128'(tiles[0][1]), 128'(2'd1));
    check("f2_yellow", 128'(tiles[0][2]), 128'(2'd2));
    check("f2_dark_red", 128'(tiles[0][3]), 128'(2'd0));
    check("f2_herr", 128'(herr_cnt), 128'(0));
    check("f2_verr", 128'(verr_cnt), 128'(0));

    // One short line while locked.
    run_frame(1, VT, 5, -1);
    check("f3_herr", 128'(herr_cnt), 128'(1));
    check("f3_locked", 128'(locked), 128'(0));
    check("f3_tv", 128'(tv_cnt), 128'(1));
    check("f3_tiles", 128'(tiles), 128'(grid_of(0)));
    check("f3_verr", 128'(verr_cnt), 128'(0));
    run_frame(1, VT, -1, -1);
    check("f4_locked", 128'(locked), 128'(0));
    check("f4_tv", 128'(tv_cnt), 128'(1));
    run_frame(1, VT, -1, -1);
    check("f5_locked", 128'(locked), 128'(1));
    run_frame(1, VT, -1, -1);
    check("f6_tv", 128'(tv_cnt), 128'(2));
    check("f6_tiles", 128'(tiles), 128'(grid_of(1)));
    check("f6_herr", 128'(herr_cnt), 128'(1));

    // Short frame: error shows at the following vs edge.
    run_frame(2, VT - 1, -1, -1);
    check("f7_tv", 128'(tv_cnt), 128'(3));
    check("f7_tiles", 128'(tiles), 128'(grid_of(2)));
    check("f7_verr", 128'(verr_cnt), 128'(0));
    check("f7_locked", 128'(locked), 128'(1));
    run_frame(3, VT, -1, -1);
    check("f8_verr", 128'(verr_cnt), 128'(1));
    check("f8_locked", 128'(locked), 128'(0));
    check("f8_tv", 128'(tv_cnt), 128'(3));
    check("f8_tiles", 128'(tiles), 128'(grid_of(2)));

    // Reset in the middle of a frame.
    run_frame(3, VT, -1, 10);
    check("f9_locked", 128'(locked), 128'(0));
    check("f9_tv", 128'(tv_cnt), 128'(3));
    check("f9_tiles", 128'(tiles), 128'(0));
    run_frame(3, VT, -1, -1);
    check("f10_locked", 128'(locked), 128'(1));
    check("f10_tv", 128'(tv_cnt), 128'(3));
    run_frame(3, VT, -1, -1);
    check("f11_tv", 128'(tv_cnt), 128'(4));
    check("f11_tiles", 128'(tiles), 128'(grid_of(3)));
    check("f11_tv_len", 128'(tv_long), 128'(0));
    check("f11_herr", 128'(herr_cnt), 128'(1));
    check("f11_verr", 128'(verr_cnt), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
